// File: rtl/instr_fetch_if.sv
// instr_fetch_if: fetch-stage bus between instr_fetch (master) and memory/hazard/EX logic (slave).
interface instr_fetch_if #(parameter int PC_WIDTH = 32);
    logic [PC_WIDTH-1:0] pc;
    logic [31:0]         instr;
    logic                stall;
    logic                redirect_valid;
    logic [PC_WIDTH-1:0] redirect_target;
    logic [31:0]         if_id_instr;
    logic [PC_WIDTH-1:0] if_id_pc1;
    logic                if_id_valid;
    logic                fetch_fault;
    modport master (
        output pc, if_id_instr, if_id_pc1, if_id_valid, fetch_fault,
        input  instr, stall, redirect_valid, redirect_target
    );
    modport slave (
        input  pc, if_id_instr, if_id_pc1, if_id_valid, fetch_fault,
        output instr, stall, redirect_valid, redirect_target
    );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: PC, IF/ID register, stall/redirect handling and sticky out-of-range fault.
// Optional FETCH_PERF_EN adds saturating perf_fetched / perf_stalls counters.
module instr_fetch #(
    parameter int PC_WIDTH  = 32,
    parameter int RESET_PC  = 0,
    parameter int MEM_DEPTH = 256
) (
    input  logic          clk,
    input  logic          rst_n,
`ifdef FETCH_PERF_EN
    output logic [31:0]   perf_fetched,
    output logic [31:0]   perf_stalls,
`endif
    instr_fetch_if.master bus
);
    localparam logic [PC_WIDTH:0] DEPTH = (PC_WIDTH+1)'(MEM_DEPTH);
    logic [PC_WIDTH-1:0] pc_q, pc_d, if_id_pc1_q, if_id_pc1_d, pc_inc;
    logic [31:0]         if_id_instr_q, if_id_instr_d;
    logic                if_id_valid_q, if_id_valid_d, fetch_fault_q, fetch_fault_d;
    logic                in_range, fetch, bubble;
    always_comb begin
        pc_inc        = pc_q + 1'b1;
        in_range      = {1'b0, pc_q} < DEPTH;
        fetch         = !bus.redirect_valid && !bus.stall && in_range;
        // out-of-range fetch behaves like a redirect bubble but leaves pc parked
        bubble        = bus.redirect_valid || (!bus.stall && !in_range);
        pc_d          = bus.redirect_valid ? bus.redirect_target : fetch ? pc_inc : pc_q;
        if_id_instr_d = fetch ? bus.instr : bubble ? 32'd0 : if_id_instr_q;
        if_id_pc1_d   = fetch ? pc_inc : bubble ? '0 : if_id_pc1_q;
        if_id_valid_d = fetch ? 1'b1 : bubble ? 1'b0 : if_id_valid_q;
        fetch_fault_d = fetch_fault_q || (!bus.redirect_valid && !bus.stall && !in_range);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= PC_WIDTH'(RESET_PC);
            if_id_instr_q <= '0;
            if_id_pc1_q   <= '0;
            if_id_valid_q <= 1'b0;
            fetch_fault_q <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_pc1_q   <= if_id_pc1_d;
            if_id_valid_q <= if_id_valid_d;
            fetch_fault_q <= fetch_fault_d;
        end
    end
    assign bus.pc          = pc_q;
    assign bus.if_id_instr = if_id_instr_q;
    assign bus.if_id_pc1   = if_id_pc1_q;
    assign bus.if_id_valid = if_id_valid_q;
    assign bus.fetch_fault = fetch_fault_q;
`ifdef FETCH_PERF_EN
    logic [31:0] fetched_q, fetched_d, stalls_q, stalls_d;
    always_comb begin
        fetched_d = (fetch && fetched_q != '1) ? fetched_q + 1'b1 : fetched_q;
        stalls_d  = (bus.stall && !bus.redirect_valid && stalls_q != '1) ? stalls_q + 1'b1 : stalls_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetched_q <= '0;
            stalls_q  <= '0;
        end else begin
            fetched_q <= fetched_d;
            stalls_q  <= stalls_d;
        end
    end
    assign perf_fetched = fetched_q;
    assign perf_stalls  = stalls_q;
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed + random stimulus against a behavioural fetch model.
module tb_instr_fetch;
    localparam int MEM_DEPTH = 256;
    logic clk, rst_n;
    logic [31:0] mem [512];
    int n_checks = 0, n_pass = 0;
    instr_fetch_if #(.PC_WIDTH(32)) ifb ();
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_stalls;
`endif
    instr_fetch #(.PC_WIDTH(32), .RESET_PC(0), .MEM_DEPTH(MEM_DEPTH)) dut (
        .clk(clk),
        .rst_n(rst_n),
`ifdef FETCH_PERF_EN
        .perf_fetched(perf_fetched),
        .perf_stalls(perf_stalls),
`endif
        .bus(ifb)
    );
    assign ifb.instr = mem[ifb.pc[8:0]];
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Behavioural model: one fetch-stage step per edge from the priority rules
    logic [31:0] m_pc, m_instr, m_pc1, m_fetched, m_stalls;
    logic        m_valid, m_fault;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = 0; m_instr = 0; m_pc1 = 0; m_valid = 0; m_fault = 0;
            m_fetched = 0; m_stalls = 0;
        end else if (ifb.redirect_valid) begin
            m_pc = ifb.redirect_target; m_instr = 0; m_pc1 = 0; m_valid = 0;
        end else if (ifb.stall) begin
            if (m_stalls != 32'hFFFF_FFFF) m_stalls = m_stalls + 1;
        end else if (m_pc < MEM_DEPTH) begin
            m_instr = mem[m_pc[8:0]]; m_pc = m_pc + 1; m_pc1 = m_pc; m_valid = 1;
            if (m_fetched != 32'hFFFF_FFFF) m_fetched = m_fetched + 1;
        end else begin
            m_instr = 0; m_pc1 = 0; m_valid = 0; m_fault = 1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("pc", ifb.pc, m_pc);
            check("if_id_instr", ifb.if_id_instr, m_instr);
            check("if_id_pc1", ifb.if_id_pc1, m_pc1);
            check("if_id_valid", ifb.if_id_valid, m_valid);
            check("fetch_fault", ifb.fetch_fault, m_fault);
`ifdef FETCH_PERF_EN
            check("perf_fetched", perf_fetched, m_fetched);
            check("perf_stalls", perf_stalls, m_stalls);
`endif
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = $urandom;
        mem[0] = 32'h4420_0001;
        mem[1] = 32'h4440_0002;
        mem[20] = 32'h0;
        rst_n = 1'b0; ifb.stall = 1'b0; ifb.redirect_valid = 1'b0; ifb.redirect_target = '0;
        repeat (2) @(negedge clk);
        check("rst pc", ifb.pc, 0);
        check("rst valid", ifb.if_id_valid, 0);
        check("rst instr", ifb.if_id_instr, 0);
        check("rst fault", ifb.fetch_fault, 0);
        rst_n = 1'b1;
        step();
        check("first instr", ifb.if_id_instr, 32'h4420_0001);
        check("first pc1", ifb.if_id_pc1, 1);
        check("first valid", ifb.if_id_valid, 1);
        step();
        check("second instr", ifb.if_id_instr, 32'h4440_0002);
        check("second pc1", ifb.if_id_pc1, 2);
        repeat (3) step();
        check("pc before stall", ifb.pc, 5);
        ifb.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall pc", ifb.pc, 5);
            check("stall pc1", ifb.if_id_pc1, 5);
        end
        ifb.stall = 1'b0;
        step();
        check("post-stall instr", ifb.if_id_instr, mem[5]);
        check("post-stall pc", ifb.pc, 6);
`ifdef FETCH_PERF_EN
        check("perf_stalls lit", perf_stalls, 3);
`endif
        step();
        ifb.redirect_valid = 1'b1; ifb.redirect_target = 12;
        step();
        ifb.redirect_valid = 1'b0;
        check("redir pc", ifb.pc, 12);
        check("redir bubble", ifb.if_id_valid, 0);
        step();
        check("redir instr", ifb.if_id_instr, mem[12]);
        check("redir pc1", ifb.if_id_pc1, 13);
        ifb.stall = 1'b1; ifb.redirect_valid = 1'b1; ifb.redirect_target = 3;
        step();
        ifb.stall = 1'b0; ifb.redirect_valid = 1'b0;
        check("redir+stall pc", ifb.pc, 3);
        check("redir+stall valid", ifb.if_id_valid, 0);
        ifb.redirect_valid = 1'b1; ifb.redirect_target = 250;
        step();
        ifb.redirect_valid = 1'b0;
        repeat (6) step();
        check("last word valid", ifb.if_id_valid, 1);
        check("last word instr", ifb.if_id_instr, mem[255]);
        check("last word pc", ifb.pc, 256);
        check("no fault yet", ifb.fetch_fault, 0);
        step();
        check("oor valid", ifb.if_id_valid, 0);
        check("oor instr", ifb.if_id_instr, 0);
        check("oor pc", ifb.pc, 256);
        check("oor fault", ifb.fetch_fault, 1);
        step();
        check("oor pc hold", ifb.pc, 256);
        ifb.redirect_valid = 1'b1; ifb.redirect_target = 0;
        step();
        ifb.redirect_valid = 1'b0;
        check("resume pc", ifb.pc, 0);
        step();
        check("resume instr", ifb.if_id_instr, 32'h4420_0001);
        check("resume valid", ifb.if_id_valid, 1);
        check("fault sticky", ifb.fetch_fault, 1);
        for (int i = 0; i < 400; i++) begin
            ifb.stall = ($urandom_range(3) == 0);
            ifb.redirect_valid = ($urandom_range(6) == 0);
            ifb.redirect_target = ($urandom_range(15) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(270));
            step();
        end
        ifb.stall = 1'b0; ifb.redirect_valid = 1'b1; ifb.redirect_target = 8;
        step();
        ifb.redirect_valid = 1'b0;
        step();
        check("pre-reset pc", ifb.pc, 9);
        check("pre-reset valid", ifb.if_id_valid, 1);
        check("pre-reset fault", ifb.fetch_fault, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async pc", ifb.pc, 0);
        check("async valid", ifb.if_id_valid, 0);
        check("async fault", ifb.fetch_fault, 0);
        check("async instr", ifb.if_id_instr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("after reset pc", ifb.pc, 1);
        check("after reset instr", ifb.if_id_instr, 32'h4420_0001);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch stage for the five-stage pipeline. It owns the program counter and drives the word address into the combinational instruction memory, which returns the instruction in the same cycle. It registers that instruction into the IF/ID pipeline register. It also handles hazard-unit stalls and EX-stage redirects (branch/jump), and flags fetches that fall outside the implemented code memory.

## Interface
Parameters:
- PC_WIDTH, 32, width of PC and all address ports
- RESET_PC, 0, word address loaded on reset
- MEM_DEPTH, 256, number of implemented instruction words; valid addresses are 0..MEM_DEPTH-1

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- pc  out  PC_WIDTH  word address to instruction memory
- instr  in  32  instruction word returned combinationally for pc
- stall  in  1  hazard unit: hold PC and IF/ID
- redirect_valid  in  1  EX stage: taken branch/jump this cycle
- redirect_target  in  PC_WIDTH  word address to fetch next
- if_id_instr  out  32  registered instruction
- if_id_pc1  out  PC_WIDTH  registered pc+1 of that instruction
- if_id_valid  out  1  IF/ID holds a real instruction (0 = bubble)
- fetch_fault  out  1  sticky: a fetch address was >= MEM_DEPTH

## Operation
- PC is a word address and increments by 1 per fetched instruction. No byte addressing.
- Next-state priority, evaluated each rising edge:
  1. Reset.
  2. redirect_valid: pc <= redirect_target; IF/ID <= bubble (instr 0, valid 0, pc1 0). Redirect overrides stall.
  3. stall: pc, if_id_instr, if_id_pc1, if_id_valid all hold.
  4. Normal fetch: pc <= pc+1; if_id_instr <= instr; if_id_pc1 <= pc+1; if_id_valid <= 1.
- Out-of-range fetch (pc >= MEM_DEPTH, normal-fetch case):
  - IF/ID is loaded with a bubble (valid 0, instr 0).
  - PC holds (no increment).
  - fetch_fault sets and stays set until reset.
  - A subsequent redirect to an in-range target resumes fetching; fault stays set.
- Arithmetic: pc+1 is modulo 2^PC_WIDTH. Wrap from all-ones to 0 is legal and not itself a fault.
- The all-zero instruction is a legal NOP. It is fetched with valid=1, never treated as a bubble marker.
- redirect_target is taken verbatim, with no range check at redirect time. The range check applies when that address is fetched.

## Timing
- Reset (asynchronous assert, synchronous-to-clk release): pc=RESET_PC, if_id_instr=0, if_id_pc1=0, if_id_valid=0, fetch_fault=0. Perf counters are 0.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge.
- Fetch latency: instruction at address A appears on if_id_instr one edge after pc==A.
- First instruction after reset release: pc=RESET_PC in the first cycle. if_id_valid=1 after the first edge.
- Redirect penalty: one bubble in IF/ID. Target instruction reaches IF/ID one edge after the bubble.
- stall and redirect_valid in the same cycle: redirect wins (rule 2).
- Stall held N cycles: outputs frozen N cycles; pc is not re-incremented.
- pc is a pure register output; there is no combinational path from any input to pc.

## Configuration
- FETCH_PERF_EN defined: adds two 32-bit read-only output ports.
  - perf_fetched: count of edges with a normal fetch that loaded valid=1.
  - perf_stalls: count of edges where stall=1 and redirect_valid=0.
  - Both counters reset to 0, saturate at all-ones, and do not count during reset.
- FETCH_PERF_EN undefined: neither port nor counter exists. All other behaviour is identical.

## Test plan
- Reset then free-run, memory preloaded with 0x44200001 at address 0 and 0x44400002 at address 1 → cycle 1: if_id_instr=0x44200001, if_id_pc1=1, valid=1. Cycle 2: if_id_instr=0x44400002, if_id_pc1=2.
- Stall held 3 cycles at pc=5 → pc stays 5 and IF/ID is unchanged for 3 cycles. After stall drops, IF/ID gets mem[5] and pc becomes 6. With FETCH_PERF_EN, perf_stalls=3.
- redirect_valid=1 with target=12 at pc=7 → next edge: pc=12, valid=0. Following edge: if_id_instr=mem[12], if_id_pc1=13.
- stall=1 and redirect_valid=1 together with target=3 → pc=3, bubble inserted. Stall is ignored for that edge.
- Run pc up to 255 then 256 with MEM_DEPTH=256 → mem[255] is fetched with valid=1. At pc=256: valid=0, pc holds 256, fetch_fault=1. Redirect to 0 resumes fetching; fetch_fault stays 1.
- Assert rst_n=0 asynchronously mid-cycle with pc=9 and valid=1 → pc=0, valid=0, fetch_fault=0 immediately, before the next edge.
